// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the 80-bit packet FIFO: packet geometry, the packet
// word type and the read-side FSM state encoding.
package fifo_pkt_pkg;

  localparam int NUM_BYTES = 10;
  localparam int BYTE_W    = 8;
  localparam int PKT_W     = NUM_BYTES * BYTE_W;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_pkt_reader.sv
// Read-domain packet consumer: fetches one packet word from the FIFO, then
// streams it out byte 0 first with a valid/ready handshake and counts
// completed packets. Outputs are registered from the next-state decode, so
// they behave exactly like Moore outputs of the state they belong to.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int NUM_BYTES = fifo_pkt_pkg::NUM_BYTES,
  parameter int BYTE_W    = fifo_pkt_pkg::BYTE_W,
  parameter int CNT_W     = 16
) (
  input  logic                        read_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  input  logic [NUM_BYTES*BYTE_W-1:0] fifo_rdata,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [BYTE_W-1:0]           m_data,
  output logic                        m_sop,
  output logic                        m_eop,
  output logic [CNT_W-1:0]            pkt_count,
  output logic                        busy
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  rd_state_t                   state_r, state_nx_s;
  logic [IDX_W-1:0]            idx_r, idx_nx_s;
  logic [NUM_BYTES*BYTE_W-1:0] buf_r, buf_nx_s;
  logic [CNT_W-1:0]            cnt_nx_s;
  logic                        fetch_ok_s;

  assign fetch_ok_s = enable && !fifo_empty;

  // Next-state, byte index, packet buffer and counter decode
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    buf_nx_s   = buf_r;
    cnt_nx_s   = pkt_count;
    case (state_r)
      IDLE: begin
        if (fetch_ok_s) begin
          state_nx_s = REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        state_nx_s = WAIT;
      end
      WAIT: begin
        // FIFO read data is valid during the cycle after the strobe
        buf_nx_s   = fifo_rdata;
        idx_nx_s   = '0;
        state_nx_s = STREAM;
      end
      STREAM: begin
        if (m_ready) begin
          if (idx_r == LAST_IDX) begin
            cnt_nx_s = pkt_count + CNT_W'(1);
            idx_nx_s = '0;
            if (fetch_ok_s) begin
              state_nx_s = REQ;
            end else begin
              state_nx_s = IDLE;
            end
          end else begin
            idx_nx_s = idx_r + IDX_W'(1);
          end
        end else begin
          // Backpressure: everything holds
          idx_nx_s = idx_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = '0;
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      buf_r      <= '0;
      pkt_count  <= '0;
      fifo_rd_en <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sop      <= 1'b0;
      m_eop      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      buf_r      <= buf_nx_s;
      pkt_count  <= cnt_nx_s;
      fifo_rd_en <= (state_nx_s == REQ);
      m_valid    <= (state_nx_s == STREAM);
      m_sop      <= (state_nx_s == STREAM) && (idx_nx_s == '0);
      m_eop      <= (state_nx_s == STREAM) && (idx_nx_s == LAST_IDX);
      busy       <= (state_nx_s != IDLE);
      if (state_nx_s == STREAM) begin
        m_data <= buf_nx_s[idx_nx_s*BYTE_W +: BYTE_W];
      end else begin
        m_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader with a behavioural FIFO read port and a
// transfer monitor that records every accepted byte with its cycle number.
module tb_fifo_pkt_reader;
  import fifo_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  pkt_t        fifo_rdata = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_sop;
  logic        m_eop;
  logic [15:0] pkt_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // FIFO model
  pkt_t fifo_mem [0:15];
  int   wp = 0;
  int   rp = 0;
  int   rd_cnt = 0;
  int   rd_empty_err = 0;
  assign fifo_empty = (wp == rp);

  // Monitor queues
  logic [7:0] byte_q[$];
  logic       sop_q[$];
  logic       eop_q[$];
  int         cyc_q[$];
  int         cyc = 0;

  fifo_pkt_reader dut (
    .read_clk  (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO read port: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= fifo_mem[rp[3:0]];
      rp <= rp + 1;
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) rd_empty_err <= rd_empty_err + 1;
    end
  end

  // Record each byte that will transfer on the coming rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (m_valid && m_ready) begin
        byte_q.push_back(m_data);
        sop_q.push_back(m_sop);
        eop_q.push_back(m_eop);
        cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input pkt_t p);
    fifo_mem[wp[3:0]] = p;
    wp = wp + 1;
  endtask

  task automatic clear_q();
    byte_q.delete(); sop_q.delete(); eop_q.delete(); cyc_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin tick(1); k++; end
    tick(1);
    check_eq(tag, 80'(byte_q.size() >= n), 80'd1);
  endtask

  task automatic wait_idx(input int n, input int budget, input string tag);
    int k = 0;
    while (!(m_valid && byte_q.size() == n) && k < budget) begin tick(1); k++; end
    check_eq(tag, 80'(m_valid && byte_q.size() == n), 80'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin tick(1); k++; end
    check_eq(tag, 80'(busy), 80'd0);
  endtask

  function automatic pkt_t mk_pkt(input logic [7:0] base);
    pkt_t p;
    for (int j = 0; j < 10; j++) p[j*8 +: 8] = base + 8'(j);
    return p;
  endfunction

  function automatic pkt_t got_pkt(input int start);
    pkt_t p = '0;
    for (int j = 0; j < 10; j++) p[j*8 +: 8] = byte_q[start + j];
    return p;
  endfunction

  initial begin
    pkt_t hello;
    pkt_t pk [0:3];
    pkt_t pe [0:2];
    logic [9:0] sopv, eopv;
    logic [7:0] exp_b [0:9];
    logic       quiet, hold_ok;
    int rd0, cnt0;
    string s;

    s = "HELLOWORLD";
    for (int j = 0; j < 10; j++) begin
      hello[j*8 +: 8] = s[j];
      exp_b[j] = s[j];
    end

    // Reset values while held in reset
    tick(2);
    check_eq("rst_outputs", {75'd0, fifo_rd_en, m_valid, m_sop, m_eop, busy}, 80'd0);
    check_eq("rst_data", 80'(m_data), 80'd0);
    rst_n = 1'b1;

    // Empty FIFO with enable high: stays quiet for 20 cycles
    quiet = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      quiet = quiet | fifo_rd_en | m_valid | busy;
    end
    check_eq("empty_quiet", 80'(quiet), 80'd0);
    check_eq("empty_count", 80'(pkt_count), 80'd0);

    // Single packet, no backpressure
    clear_q();
    push(hello);
    wait_bytes(10, 60, "hello_timeout");
    tick(3);
    check_eq("hello_rd_pulses", 80'(rd_cnt), 80'd1);
    check_eq("hello_nbytes", 80'(byte_q.size()), 80'd10);
    for (int j = 0; j < 10; j++) check_eq("hello_byte", 80'(byte_q[j]), 80'(exp_b[j]));
    for (int j = 0; j < 10; j++) begin sopv[j] = sop_q[j]; eopv[j] = eop_q[j]; end
    check_eq("hello_sop", 80'(sopv), 80'h001);
    check_eq("hello_eop", 80'(eopv), 80'h200);
    check_eq("hello_back2back", 80'(cyc_q[9] - cyc_q[0]), 80'd9);
    check_eq("hello_count", 80'(pkt_count), 80'd1);
    check_eq("hello_idle", 80'(busy), 80'd0);

    // Backpressure at byte index 3
    clear_q();
    push(hello);
    wait_idx(3, 60, "bp_reach_idx3");
    m_ready = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(m_valid && m_data == 8'h4C && !m_sop && !m_eop)) hold_ok = 1'b0;
      tick(1);
    end
    check_eq("bp_hold", 80'(hold_ok), 80'd1);
    check_eq("bp_no_xfer", 80'(byte_q.size()), 80'd3);
    m_ready = 1'b1;
    wait_bytes(10, 40, "bp_timeout");
    tick(2);
    check_eq("bp_nbytes", 80'(byte_q.size()), 80'd10);
    check_eq("bp_packet", got_pkt(0), hello);
    check_eq("bp_count", 80'(pkt_count), 80'd2);

    // Four preloaded packets streamed back to back
    enable = 1'b0;
    clear_q();
    rd0 = rd_cnt;
    for (int k = 0; k < 4; k++) begin
      pk[k] = mk_pkt(8'(8'h10 + 8'h10 * k));
      push(pk[k]);
    end
    tick(2);
    enable = 1'b1;
    wait_bytes(40, 300, "multi_timeout");
    wait_idle(20, "multi_idle");
    check_eq("multi_nbytes", 80'(byte_q.size()), 80'd40);
    for (int k = 0; k < 4; k++) begin
      check_eq("multi_packet", got_pkt(10 * k), pk[k]);
      check_eq("multi_in_pkt_gap", 80'(cyc_q[10*k+9] - cyc_q[10*k]), 80'd9);
      if (k > 0) check_eq("multi_between_gap", 80'(cyc_q[10*k] - cyc_q[10*k-1]), 80'd3);
    end
    check_eq("multi_rd_pulses", 80'(rd_cnt - rd0), 80'd4);
    check_eq("multi_count", 80'(pkt_count), 80'd6);

    // Enable dropped mid-packet with packets still queued
    clear_q();
    rd0 = rd_cnt;
    cnt0 = int'(pkt_count);
    for (int k = 0; k < 3; k++) begin
      pe[k] = mk_pkt(8'(8'hA0 + 8'h10 * k));
      push(pe[k]);
    end
    wait_idx(5, 60, "en_reach_idx5");
    enable = 1'b0;
    wait_idle(40, "en_idle");
    tick(10);
    check_eq("en_nbytes", 80'(byte_q.size()), 80'd10);
    check_eq("en_packet", got_pkt(0), pe[0]);
    check_eq("en_rd_pulses", 80'(rd_cnt - rd0), 80'd1);
    check_eq("en_count_delta", 80'(int'(pkt_count) - cnt0), 80'd1);
    check_eq("en_fifo_left", 80'(wp - rp), 80'd2);

    // Reset in the middle of a packet
    clear_q();
    enable = 1'b1;
    wait_idx(6, 60, "rst_reach_idx6");
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outputs", {75'd0, fifo_rd_en, m_valid, m_sop, m_eop, busy}, 80'd0);
    check_eq("midrst_data_count", {56'd0, m_data, pkt_count}, 80'd0);
    tick(2);
    clear_q();
    rst_n = 1'b1;
    wait_bytes(10, 60, "post_rst_timeout");
    tick(3);
    check_eq("post_rst_sop", 80'(sop_q[0]), 80'd1);
    check_eq("post_rst_packet", got_pkt(0), pe[2]);
    check_eq("post_rst_count", 80'(pkt_count), 80'd1);
    check_eq("rd_while_empty", 80'(rd_empty_err), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
Read-side consumer for the dual-clock 80-bit packet FIFO, clocked in the read domain. Drains one 10-byte packet at a time from the FIFO read port and emits it as a byte stream with valid/ready handshake, byte 0 first. Byte j is data[j*8 +: 8], matching the packing used on the write side. Also maintains a count of completed packets for status and scoreboarding.

Parameters:
NUM_BYTES, 10, bytes per packet
BYTE_W, 8, bits per byte
CNT_W, 16, width of the completed-packet counter

Ports:
read_clk  input  1  read-domain clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits fetching new packets from the FIFO
fifo_empty  input  1  FIFO empty flag (read domain)
fifo_rd_en  output  1  single-cycle FIFO read strobe
fifo_rdata  input  NUM_BYTES*BYTE_W  FIFO read data, valid the cycle after fifo_rd_en
m_valid  output  1  output byte valid
m_ready  input  1  downstream accepts byte
m_data  output  BYTE_W  current byte
m_sop  output  1  high with byte index 0
m_eop  output  1  high with byte index NUM_BYTES-1
pkt_count  output  CNT_W  completed packets, wraps modulo 2^CNT_W
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; fifo_rd_en=0; m_valid=0; m_data=0; m_sop=0; m_eop=0; pkt_count=0; busy=0; idx=0; packet buffer=0.
- States: IDLE, REQ, WAIT, STREAM.
- IDLE: if enable && !fifo_empty, go to REQ; otherwise stay.
- REQ: fifo_rd_en=1 for exactly this cycle (Moore output); go to WAIT.
- WAIT: capture fifo_rdata into the packet buffer; idx=0; go to STREAM.
- STREAM outputs:
  - m_valid=1; m_data=buf[idx*BYTE_W +: BYTE_W].
  - m_sop=(idx==0); m_eop=(idx==NUM_BYTES-1).
- STREAM handshake: a transfer occurs when m_valid && m_ready.
  - Non-final byte: idx++.
  - Final byte (idx==NUM_BYTES-1): pkt_count++. Then go to REQ if enable && !fifo_empty, else IDLE.
- Backpressure: while m_ready=0, m_data, m_sop, m_eop and idx hold stable. m_valid never drops mid-packet.
- At most one FIFO read is in flight. fifo_rd_en is never asserted while fifo_empty=1 was sampled in the deciding cycle. fifo_rd_en is never asserted in WAIT or STREAM.
- Latency: fifo_empty falls in IDLE -> fifo_rd_en 1 cycle later -> first m_valid 3 cycles after that sample.
- Throughput: 1 byte/cycle within a packet; minimum 2 idle cycles (REQ, WAIT) between packets.
- enable deasserted mid-packet: current packet completes; no new fetch.
- Reset mid-packet: partial packet discarded; no partial pkt_count increment.
- pkt_count wraps from 0xFFFF to 0x0000.

Decomposition:
- Shared package fifo_pkt_pkg holds:
  - NUM_BYTES, BYTE_W and PKT_W=NUM_BYTES*BYTE_W, shared with the FIFO and the write side.
  - typedef pkt_t = logic [PKT_W-1:0].
  - Enum rd_state_t {IDLE, REQ, WAIT, STREAM}.
- No sub-module: byte select, FSM and counter fit in one module.

Test Plan:
- Reset with FIFO empty, enable=1 -> fifo_rd_en stays 0, m_valid=0, pkt_count=0, busy=0 for 20 cycles.
- One packet "HELLOWORLD" (byte0=0x48 ... byte9=0x44), m_ready=1:
  - exactly one fifo_rd_en pulse;
  - 10 consecutive bytes 0x48,0x45,0x4C,0x4C,0x4F,0x57,0x4F,0x52,0x4C,0x44;
  - m_sop on 0x48, m_eop on 0x44;
  - pkt_count=1, then IDLE.
- Backpressure: m_ready low for 5 cycles at idx=3 -> m_data holds 0x4C with m_valid=1 throughout; stream resumes at idx=3 with no byte lost or duplicated.
- Four packets preloaded in the FIFO, m_ready=1:
  - 40 bytes out in order;
  - exactly 2 non-valid cycles between packets;
  - pkt_count=4; fifo_rd_en never asserted while fifo_empty=1.
- enable dropped at idx=5 with packets remaining -> current packet finishes; no further fifo_rd_en; pkt_count increments by 1 only.
- rst_n asserted at idx=6 -> outputs return to reset values immediately. After release with the FIFO non-empty, the next packet starts at idx=0 with m_sop=1.
